// File: rtl/huffman_pkg.sv
// Shared types and constants for the Huffman bit-feed controller.
// Symbol codes 1..18 are the only legal decoder outputs.
package huffman_pkg;

    localparam int SYM_W   = 5;
    localparam int SYM_MIN = 1;
    localparam int SYM_MAX = 18;

    typedef logic [SYM_W-1:0] sym_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } feed_state_t;

    function automatic logic sym_in_range(input sym_t s);
        return (s >= sym_t'(SYM_MIN)) && (s <= sym_t'(SYM_MAX));
    endfunction

endpackage

// File: rtl/huffman_feed_ctrl_if.sv
// Byte-in and symbol-out valid/ready streams of the feed controller.
// The controller takes the slave side; the producer/consumer the master side.
interface huffman_feed_ctrl_if;
    import huffman_pkg::*;

    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    sym_t       sym_data;
    logic       sym_valid;
    logic       sym_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output sym_data,
        output sym_valid,
        input  sym_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  sym_data,
        input  sym_valid,
        output sym_ready
    );

endinterface

// File: rtl/huffman_sym_fifo.sv
// Small synchronous symbol FIFO with a free-entry count.
// DEPTH must be a power of two so the pointers wrap naturally.
module huffman_sym_fifo
    import huffman_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  sym_t                     wdata,
    input  logic                     pop,
    output sym_t                     rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   free_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sym_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    // Storage is not reset, so the output is masked while empty.
    assign valid    = (cnt_q != '0);
    assign rdata    = valid ? mem_q[rd_q] : '0;
    assign free_cnt = CW'(DEPTH) - cnt_q;

endmodule

// File: rtl/huffman_feed_ctrl.sv
// Frame sequencer: serialises code bytes into the Huffman decoder and
// queues decoded symbols until the programmed frame length is reached.
module huffman_feed_ctrl
    import huffman_pkg::*;
#(
    parameter int OUT_DEPTH = 4,
    parameter int LEN_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_W-1:0]     frame_len,
    huffman_feed_ctrl_if.slave   bus,
    output logic                 dec_bit_in,
    output logic                 dec_bit_en,
    output logic                 dec_clear,
    input  sym_t                 dec_symbol,
    input  logic                 dec_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int CW = $clog2(OUT_DEPTH) + 1;

    feed_state_t      state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       sreg_q, sreg_d;
    logic [3:0]       bits_q, bits_d;
    logic             err_q, err_d;
    logic             clr_q, clr_d;

    logic [CW-1:0]    free_cnt;
    logic             run, load, issue, capture, sym_ok;
    logic             fifo_push, fifo_pop, last;

    always_comb begin
        run       = (state_q == RUN);
        load      = run && (bits_q == 4'd0) && bus.in_valid;
        capture   = run && dec_valid && (rem_q != '0);
        sym_ok    = sym_in_range(dec_symbol);
        fifo_push = capture && sym_ok;
        last      = fifo_push && (rem_q == LEN_W'(1));
        fifo_pop  = bus.sym_valid && bus.sym_ready;
        // A second free slot covers the symbol still inside the decoder.
        issue     = run && (bits_q != 4'd0) &&
                    (free_cnt >= CW'(2)) && !last;
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        sreg_d  = sreg_q;
        bits_d  = bits_q;
        err_d   = err_q;
        clr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    rem_d = frame_len;
                    if (frame_len == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        clr_d   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (load) begin
                    sreg_d = bus.in_data;
                    bits_d = 4'd8;
                end else if (issue) begin
                    sreg_d = {sreg_q[6:0], 1'b0};
                    bits_d = bits_q - 4'd1;
                end
                if (capture && !sym_ok) err_d = 1'b1;
                if (fifo_push) rem_d = rem_q - LEN_W'(1);
                if (last) begin
                    state_d = DRAIN;
                    bits_d  = 4'd0;
                end
            end
            DRAIN: begin
                if ((free_cnt == CW'(OUT_DEPTH)) ||
                    ((free_cnt == CW'(OUT_DEPTH - 1)) && fifo_pop))
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            sreg_q  <= '0;
            bits_q  <= '0;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            sreg_q  <= sreg_d;
            bits_q  <= bits_d;
            err_q   <= err_d;
            clr_q   <= clr_d;
        end
    end

    huffman_sym_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .wdata    (dec_symbol),
        .pop      (fifo_pop),
        .rdata    (bus.sym_data),
        .valid    (bus.sym_valid),
        .free_cnt (free_cnt)
    );

    assign bus.in_ready = run && (bits_q == 4'd0);
    assign dec_bit_en   = issue;
    assign dec_bit_in   = issue & sreg_q[7];
    assign dec_clear    = clr_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_huffman_feed_ctrl.sv
// Directed bench for huffman_feed_ctrl with a small behavioural decoder.
// Mode 0: prefix code, mode 1: one symbol per bit, mode 2: manual symbols.
module tb_huffman_feed_ctrl;
    import huffman_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] frame_len;
    logic        dec_bit_in, dec_bit_en, dec_clear;
    sym_t        dec_symbol;
    logic        dec_valid;
    logic        busy, done, err;

    huffman_feed_ctrl_if bus();

    huffman_feed_ctrl #(.OUT_DEPTH(4), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame_len  (frame_len),
        .bus        (bus),
        .dec_bit_in (dec_bit_in),
        .dec_bit_en (dec_bit_en),
        .dec_clear  (dec_clear),
        .dec_symbol (dec_symbol),
        .dec_valid  (dec_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   mode = 0;
    logic man_valid = 1'b0;
    sym_t man_sym = '0;
    logic mdl_valid;
    sym_t mdl_sym, seq, tsym;
    logic [1:0] acc, alen, nl;
    logic [2:0] nb;

    assign dec_valid  = (mode == 2) ? man_valid : mdl_valid;
    assign dec_symbol = (mode == 2) ? man_sym : mdl_sym;

    // Code table: 00->7, 01->9, 11->18, 100->12, 101->3
    always_comb begin
        nb   = {acc, dec_bit_in};
        nl   = alen + 2'd1;
        tsym = '0;
        if (nl == 2'd2 && nb[1:0] == 2'b00) tsym = 5'd7;
        else if (nl == 2'd2 && nb[1:0] == 2'b01) tsym = 5'd9;
        else if (nl == 2'd2 && nb[1:0] == 2'b11) tsym = 5'd18;
        else if (nl == 2'd3) tsym = nb[0] ? 5'd3 : 5'd12;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_valid <= 1'b0;
            mdl_sym   <= '0;
            seq       <= 5'd1;
            acc       <= '0;
            alen      <= '0;
        end else begin
            mdl_valid <= 1'b0;
            if (dec_clear) begin
                seq  <= 5'd1;
                acc  <= '0;
                alen <= '0;
            end else if (dec_bit_en) begin
                if (mode == 1) begin
                    mdl_valid <= 1'b1;
                    mdl_sym   <= seq;
                    seq       <= seq + 5'd1;
                end else if (tsym != '0) begin
                    mdl_valid <= 1'b1;
                    mdl_sym   <= tsym;
                    acc       <= '0;
                    alen      <= '0;
                end else begin
                    acc  <= nb[1:0];
                    alen <= nl;
                end
            end
        end
    end

    logic [7:0] bit_word;
    int         nbits, nclr, first_bit_at, last_bit_at;
    int         last_hs_at, done_at;
    logic       busy_after;
    sym_t       got_q[$];
    logic [7:0] feed_q[$];

    task automatic reset_stats();
        bit_word     = '0;
        nbits        = 0;
        nclr         = 0;
        first_bit_at = -1;
        last_bit_at  = -1;
        last_hs_at   = -1;
        done_at      = -1;
        busy_after   = 1'b1;
        got_q.delete();
        feed_q.delete();
    endtask

    task automatic start_frame(input logic [15:0] len);
        @(negedge clk);
        start     = 1'b1;
        frame_len = len;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic collect(input int max_cyc, input bit stop_on_done);
        done_at = -1;
        for (int c = 0; c < max_cyc; c++) begin
            if (dec_bit_en) begin
                bit_word = {bit_word[6:0], dec_bit_in};
                if (nbits == 0) first_bit_at = c;
                last_bit_at = c;
                nbits++;
            end
            if (dec_clear) nclr++;
            if (bus.sym_valid && bus.sym_ready) begin
                got_q.push_back(bus.sym_data);
                last_hs_at = c;
            end
            if (done && done_at < 0) done_at = c;
            if (bus.in_ready && feed_q.size() > 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = feed_q.pop_front();
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            start = 1'b0;
            if (stop_on_done && done_at >= 0) begin
                busy_after = busy;
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        frame_len = '0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.sym_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, bus.in_ready, bus.sym_valid,
             dec_bit_en, dec_clear, dec_bit_in} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outs: got %b want 00000000",
                {busy, done, err, bus.in_ready, bus.sym_valid,
                 dec_bit_en, dec_clear, dec_bit_in});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, bus.sym_valid, bus.sym_data} !== 7'h00) begin
            errors++;
            $display("FAIL reset_release: got %h want 00",
                {busy, bus.sym_valid, bus.sym_data});
        end
    endtask

    task automatic test_zero_len();
        reset_stats();
        start_frame(16'd0);
        checks++;
        if ({done, busy, bus.in_ready, dec_bit_en, dec_clear} !== 5'b11000) begin
            errors++;
            $display("FAIL zero_t1: got %b want 11000",
                {done, busy, bus.in_ready, dec_bit_en, dec_clear});
        end
        @(negedge clk);
        checks++;
        if ({done, busy, bus.in_ready, dec_bit_en, dec_clear} !== 5'b00000) begin
            errors++;
            $display("FAIL zero_t2: got %b want 00000",
                {done, busy, bus.in_ready, dec_bit_en, dec_clear});
        end
    endtask

    task automatic test_single_byte();
        reset_stats();
        mode = 0;
        bus.sym_ready = 1'b1;
        feed_q.push_back(8'hA5);
        start_frame(16'd3);
        checks++;
        if ({dec_clear, bus.in_ready, busy} !== 3'b111) begin
            errors++;
            $display("FAIL single_t1: got %b want 111",
                {dec_clear, bus.in_ready, busy});
        end
        collect(60, 1'b1);
        checks++;
        if (nbits !== 8 || bit_word !== 8'hA5) begin
            errors++;
            $display("FAIL single_bits: got n=%0d w=%h want n=8 w=a5",
                nbits, bit_word);
        end
        checks++;
        if (first_bit_at !== 1 || last_bit_at !== 8) begin
            errors++;
            $display("FAIL single_bit_timing: got %0d..%0d want 1..8",
                first_bit_at, last_bit_at);
        end
        checks++;
        if (got_q.size() !== 3) begin
            errors++;
            $display("FAIL single_nsym: got %0d want 3", got_q.size());
        end else begin
            checks++;
            if ({got_q[0], got_q[1], got_q[2]} !== {5'd3, 5'd7, 5'd3}) begin
                errors++;
                $display("FAIL single_syms: got %0d %0d %0d want 3 7 3",
                    got_q[0], got_q[1], got_q[2]);
            end
        end
        checks++;
        if (done_at < 0 || done_at !== last_hs_at + 1) begin
            errors++;
            $display("FAIL single_done: got %0d want %0d",
                done_at, last_hs_at + 1);
        end
        checks++;
        if (busy_after !== 1'b0 || nclr !== 1) begin
            errors++;
            $display("FAIL single_end: got busy=%b clr=%0d want 0 1",
                busy_after, nclr);
        end
    endtask

    task automatic test_backpressure();
        reset_stats();
        mode = 1;
        bus.sym_ready = 1'b0;
        feed_q.push_back(8'hFF);
        feed_q.push_back(8'hFF);
        start_frame(16'd10);
        collect(30, 1'b0);
        checks++;
        if (nbits !== 4 || dec_bit_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall: got bits=%0d en=%b want 4 0",
                nbits, dec_bit_en);
        end
        checks++;
        if (bus.sym_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got v=%b b=%b want 1 1",
                bus.sym_valid, busy);
        end
        bus.sym_ready = 1'b1;
        collect(120, 1'b1);
        checks++;
        if (nbits !== 10 || got_q.size() !== 10) begin
            errors++;
            $display("FAIL bp_count: got bits=%0d syms=%0d want 10 10",
                nbits, got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== sym_t'(i + 1)) begin
                errors++;
                $display("FAIL bp_sym%0d: got %0d want %0d",
                    i, got_q[i], i + 1);
            end
        end
        checks++;
        if (done_at < 0 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL bp_done: got done_at=%0d busy=%b want >=0 0",
                done_at, busy_after);
        end
    endtask

    task automatic test_bad_symbols();
        reset_stats();
        mode = 2;
        bus.sym_ready = 1'b1;
        start_frame(16'd2);
        man_valid = 1'b1;
        man_sym   = 5'd0;
        @(negedge clk);
        checks++;
        if ({err, bus.sym_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bad_zero: got %b want 10", {err, bus.sym_valid});
        end
        man_sym = 5'd19;
        @(negedge clk);
        checks++;
        if ({err, bus.sym_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bad_19: got %b want 10", {err, bus.sym_valid});
        end
        man_sym = 5'd5;
        @(negedge clk);
        man_valid = 1'b0;
        checks++;
        if ({bus.sym_valid, bus.sym_data} !== {1'b1, 5'd5}) begin
            errors++;
            $display("FAIL bad_good1: got %b/%0d want 1/5",
                bus.sym_valid, bus.sym_data);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, bus.sym_valid} !== 3'b100) begin
            errors++;
            $display("FAIL bad_remaining: got %b want 100",
                {busy, done, bus.sym_valid});
        end
        man_valid = 1'b1;
        man_sym   = 5'd6;
        @(negedge clk);
        man_valid = 1'b0;
        checks++;
        if ({bus.sym_valid, bus.sym_data} !== {1'b1, 5'd6}) begin
            errors++;
            $display("FAIL bad_good2: got %b/%0d want 1/6",
                bus.sym_valid, bus.sym_data);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL bad_done: got %b want 1", done);
        end
        @(negedge clk);
        checks++;
        if ({busy, err} !== 2'b01) begin
            errors++;
            $display("FAIL bad_sticky: got %b want 01", {busy, err});
        end
        start_frame(16'd0);
        checks++;
        if ({err, done} !== 2'b01) begin
            errors++;
            $display("FAIL bad_clear: got %b want 01", {err, done});
        end
        @(negedge clk);
        mode = 0;
    endtask

    task automatic test_reset_mid();
        reset_stats();
        mode = 1;
        bus.sym_ready = 1'b0;
        feed_q.push_back(8'hFF);
        start_frame(16'd10);
        collect(20, 1'b0);
        checks++;
        if (nbits !== 4 || bus.sym_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill: got bits=%0d v=%b want 4 1",
                nbits, bus.sym_valid);
        end
        bus.sym_ready = 1'b1;
        collect(2, 1'b0);
        bus.sym_ready = 1'b0;
        for (int i = 0; i < 10 && nbits < 5; i++) collect(1, 1'b0);
        checks++;
        if (nbits !== 5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: got bits=%0d busy=%b want 5 1",
                nbits, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, bus.in_ready, bus.sym_valid,
             dec_bit_en, dec_clear, dec_bit_in} !== 8'h00 ||
            bus.sym_data !== 5'd0) begin
            errors++;
            $display("FAIL mid_async: got %b/%0d want 00000000/0",
                {busy, done, err, bus.in_ready, bus.sym_valid,
                 dec_bit_en, dec_clear, dec_bit_in}, bus.sym_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy, bus.sym_valid} !== 2'b00) begin
            errors++;
            $display("FAIL mid_edge: got %b want 00", {busy, bus.sym_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        reset_stats();
        bus.sym_ready = 1'b1;
        feed_q.push_back(8'h80);
        start_frame(16'd1);
        collect(40, 1'b1);
        checks++;
        if (got_q.size() !== 1 || nclr !== 1 || nbits !== 1) begin
            errors++;
            $display("FAIL mid_restart: got syms=%0d clr=%0d bits=%0d want 1 1 1",
                got_q.size(), nclr, nbits);
        end else begin
            checks++;
            if (got_q[0] !== 5'd1 || busy_after !== 1'b0) begin
                errors++;
                $display("FAIL mid_restart_sym: got %0d/%b want 1/0",
                    got_q[0], busy_after);
            end
        end
    endtask

    task automatic test_start_busy();
        reset_stats();
        mode = 1;
        bus.sym_ready = 1'b1;
        feed_q.push_back(8'hFF);
        start_frame(16'd3);
        start     = 1'b1;
        frame_len = 16'd7;
        collect(60, 1'b1);
        checks++;
        if (got_q.size() !== 3 || nbits !== 3 || nclr !== 1) begin
            errors++;
            $display("FAIL busy_count: got syms=%0d bits=%0d clr=%0d want 3 3 1",
                got_q.size(), nbits, nclr);
        end else begin
            checks++;
            if ({got_q[0], got_q[1], got_q[2]} !== {5'd1, 5'd2, 5'd3}) begin
                errors++;
                $display("FAIL busy_syms: got %0d %0d %0d want 1 2 3",
                    got_q[0], got_q[1], got_q[2]);
            end
        end
        checks++;
        if (done_at < 0 || busy_after !== 1'b0) begin
            errors++;
            $display("FAIL busy_done: got done_at=%0d busy=%b want >=0 0",
                done_at, busy_after);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_zero_len();
        test_single_byte();
        test_backpressure();
        test_bad_symbols();
        test_reset_mid();
        test_start_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/huffman_feed_ctrl.md
# huffman_feed_ctrl

Frame-level sequencer for the serial Huffman decoder. It accepts packed 8-bit code words over a valid/ready stream and feeds them MSB-first, one bit per cycle, into the decoder's `bit_in`. It collects decoded symbols into a small output FIFO with backpressure and stops after a programmed number of symbols per frame. It sits between the compressed-data source and the symbol consumer and owns the decoder's bit-enable and tree-clear.

## Interface

**Parameters**

- `OUT_DEPTH`, default 4: output symbol FIFO depth; legal values are ≥2 and a power of two.
- `LEN_W`, default 16: width of the frame symbol counter.

**Ports**

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle frame start request; honoured only in IDLE.
- `frame_len` in LEN_W: number of symbols in the frame; sampled when `start` is accepted.
- `in_data` in 8: packed code bits, MSB transmitted first.
- `in_valid` in 1 / `in_ready` out 1: input byte handshake.
- `dec_bit_in` out 1: bit to the decoder's `bit_in`.
- `dec_bit_en` out 1: the decoder consumes `dec_bit_in` only in cycles where this is 1.
- `dec_clear` out 1: one-cycle pulse that returns the decoder tree to its root.
- `dec_symbol` in 5 / `dec_valid` in 1: decoded symbol from the decoder.
- `sym_data` out 5 / `sym_valid` out 1 / `sym_ready` in 1: symbol output handshake.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame completion.
- `err` out 1: sticky out-of-range-symbol flag; cleared by an accepted `start`.

## Operation

**Reset values.** `rst` forces all outputs to 0, the FIFO to empty, the counters to 0 and the state to IDLE, from any state.

**States**

- **IDLE**
  - `start`=1 and `frame_len`=0 → DONE.
  - `start`=1 and `frame_len`≠0 → RUN. On entry: `remaining`←`frame_len`, `err`←0, `dec_clear`=1 in the first RUN cycle.
- **RUN**: an 8-bit shift register plus `bits_left` (4 bits).
  - `in_ready` = (`bits_left`==0).
  - A byte handshake loads the register with `bits_left`=8. No bit is issued in the load cycle.
  - A bit is issued when `bits_left`≠0 **and** FIFO free entries ≥2. The second free entry reserves room for one in-flight symbol. The bit issued is `dec_bit_in`=reg[7] with `dec_bit_en`=1; the register then shifts left and `bits_left` decrements.
- **Symbol capture**
  - When `dec_valid`=1 and `dec_symbol` is in 1..18 and `remaining`≠0: write the symbol to the FIFO and decrement `remaining`.
  - A symbol of 0 or 19..31 is dropped, not counted, and sets `err`=1.
  - `dec_valid` while `remaining`=0 or in IDLE/DONE is ignored.
- When `remaining` reaches 0 → DRAIN. Bit issue stops immediately, and any bits left in the shift register are discarded.
- **DRAIN**: wait for the FIFO to be empty → DONE.
- **DONE**: `done`=1 for one cycle → IDLE.

**Other rules**

- `start` while `busy`=1 is ignored.
- `in_ready` is 0 outside RUN.
- A simultaneous FIFO write and read is legal at any occupancy.

## Timing

- `start` accepted at cycle t: `busy`=1, `dec_clear`=1 and `in_ready`=1 at t+1.
- Byte handshake at cycle u: bits are issued at u+1..u+8 when there is no backpressure. Peak throughput is 8 bits per 9 cycles.
- The decoder's `dec_valid` appears the cycle after the `dec_bit_en` that completes a code.
- A symbol written at cycle v is visible on `sym_data`/`sym_valid` at v+1.
- The last symbol is accepted downstream at cycle w: `done`=1 at w+1 and `busy`=0 at w+2.
- `frame_len`=0 with `start` at t: `done`=1 at t+1, and `in_ready` is never asserted.
- No symbol is ever lost due to a full FIFO. This follows from the free-entries ≥2 gate.

## Structure

- Shared package `huffman_pkg` holds:
  - `SYM_W`=5, `SYM_MIN`=1, `SYM_MAX`=18.
  - The `feed_state_t` enum {IDLE, RUN, DRAIN, DONE}.
  - The `sym_t` typedef.
- Sub-module `huffman_sym_fifo`: synchronous FIFO, parameter `DEPTH`, with `free_cnt` output and the same `clk`/`rst` convention. The controller FSM, shift register and counters stay in the top-level module.

## Test plan

- **Zero-length frame.** `frame_len`=0, `start` pulse → `done` at t+1; `in_ready`, `dec_bit_en` and `dec_clear` never go high; `busy` stays 1 for exactly one cycle.
- **Single byte, three symbols.** `frame_len`=3, byte 0xA5, `sym_ready`=1, bench decoder model → `dec_clear` at t+1; `dec_bit_in` sequence 1,0,1,0,0,1,0,1; three symbols out in order; `done` one cycle after the third symbol handshake.
- **Backpressure.** `OUT_DEPTH`=4, `sym_ready`=0, `frame_len`=10, one symbol per bit → `dec_bit_en` stops once FIFO free <2 and the FIFO holds ≤4 symbols; release `sym_ready` → all 10 symbols arrive, none dropped or duplicated.
- **Bad symbols.** Decoder injects symbol 0 and then 19 mid-frame → `err`=1, neither symbol appears on `sym_data`, `remaining` is unchanged. The next `start` clears `err` to 0.
- **Reset mid-frame.** Assert `rst` during RUN with 3 bits left and 2 symbols queued → all outputs 0, `sym_valid`=0 and FIFO empty on the next edge. A new `start` then works normally.
- **Start while busy.** A `start` pulse during RUN with a different `frame_len` is ignored, and the frame ends after the original count.
